// File: rtl/cmd_dispatch_ctrl_pkg.sv
// cmd_dispatch_ctrl_pkg
//   Shared types and constants for the command dispatch controller:
//   the dispatch state encoding and the credit-counter width.
package cmd_dispatch_ctrl_pkg;

    // Dispatch state: RUN accepts instructions, DRAIN waits for all credits.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Credit counters cover up to 15 slots per queue.
    localparam int CRED_W = 4;

endpackage

// File: rtl/cmd_dispatch_ctrl_if.sv
// cmd_dispatch_ctrl_if
//   Bundles the dispatch handshake: instruction/payload/flush/credit-return
//   inputs toward the controller and fire/replay/enqueue/status outputs.
//   master : the instruction source and downstream queues (drives inputs)
//   slave  : the controller
interface cmd_dispatch_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              io_valid;
    logic              io_sigs_enq_cmdq;
    logic              io_sigs_enq_ximm1q;
    logic [DATA_W-1:0] io_cmd_bits;
    logic [DATA_W-1:0] io_imm_bits;
    logic              io_flush;
    logic              io_cmdq_credit_return;
    logic              io_ximm1q_credit_return;
    logic              io_replay;
    logic              io_fire;
    logic              io_cmdq_valid;
    logic              io_ximm1q_valid;
    logic [DATA_W-1:0] io_cmdq_bits;
    logic [DATA_W-1:0] io_ximm1q_bits;
    logic              io_busy;
    logic              io_credit_err;

    modport master (
        output io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q, io_cmd_bits,
               io_imm_bits, io_flush, io_cmdq_credit_return, io_ximm1q_credit_return,
        input  io_replay, io_fire, io_cmdq_valid, io_ximm1q_valid, io_cmdq_bits,
               io_ximm1q_bits, io_busy, io_credit_err
    );

    modport slave (
        input  io_valid, io_sigs_enq_cmdq, io_sigs_enq_ximm1q, io_cmd_bits,
               io_imm_bits, io_flush, io_cmdq_credit_return, io_ximm1q_credit_return,
        output io_replay, io_fire, io_cmdq_valid, io_ximm1q_valid, io_cmdq_bits,
               io_ximm1q_bits, io_busy, io_credit_err
    );
endinterface

// File: rtl/cmd_dispatch_ctrl_credit_counter.sv
// credit_counter
//   Per-queue slot credit counter, reset to CREDITS (1..15).
//   consume_i    : one slot taken by an enqueue this cycle
//   return_i     : one slot freed downstream this cycle
//   count_o      : current credit count
//   has_credit_o : count >= 1
//   at_max_o     : count == CREDITS
//   overflow_o   : return with no consume while already full (pulse)
module credit_counter
    import cmd_dispatch_ctrl_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              consume_i,
    input  logic              return_i,
    output logic [CRED_W-1:0] count_o,
    output logic              has_credit_o,
    output logic              at_max_o,
    output logic              overflow_o
);
    localparam logic [CRED_W-1:0] MAX = CRED_W'(CREDITS);

    logic [CRED_W-1:0] count_q, count_d;

    assign count_o      = count_q;
    assign has_credit_o = (count_q != '0);
    assign at_max_o     = (count_q == MAX);
    // A same-cycle consume absorbs the return, so that case is never an overflow.
    assign overflow_o   = return_i && !consume_i && at_max_o;

    always_comb begin
        count_d = count_q;
        if (consume_i && !return_i)
            count_d = count_q - CRED_W'(1);
        else if (return_i && !consume_i && !at_max_o)
            count_d = count_q + CRED_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= MAX;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/cmd_dispatch_ctrl.sv
// cmd_dispatch_ctrl
//   Credit-gated dispatch of decoded instructions into cmdq and ximm1q.
//   An instruction fires only when every queue it needs has a credit; both
//   enqueues happen together or not at all. A flush moves to DRAIN, which
//   blocks dispatch until every outstanding credit has come back.
//   clk, reset : clock, asynchronous active-high reset
//   io (slave) : instruction/payload/flush/credit returns in;
//                fire/replay, registered enqueue strobes+payloads,
//                busy (DRAIN) and sticky credit-overflow flag out.
module cmd_dispatch_ctrl
    import cmd_dispatch_ctrl_pkg::*;
#(
    parameter int CMDQ_CREDITS   = 4,
    parameter int XIMM1Q_CREDITS = 2,
    parameter int DATA_W         = 32
) (
    input  logic                clk,
    input  logic                reset,
    cmd_dispatch_ctrl_if.slave  io
);
    state_e            state_q, state_d;
    logic              fire;
    logic              cmdq_has, ximm_has, cmdq_full, ximm_full;
    logic              cmdq_ovf, ximm_ovf;
    logic [CRED_W-1:0] cmdq_cnt, ximm_cnt;
    logic              cmdq_valid_q, ximm_valid_q, err_q;
    logic [DATA_W-1:0] cmdq_bits_q, ximm_bits_q;

    // Flush wins over a same-cycle valid; reset forces the no-fire view.
    always_comb begin
        fire = !reset && io.io_valid && (state_q == RUN) && !io.io_flush
            && (!io.io_sigs_enq_cmdq   || cmdq_has)
            && (!io.io_sigs_enq_ximm1q || ximm_has);
    end

    credit_counter #(.CREDITS(CMDQ_CREDITS)) u_cmdq_cnt (
        .clk          (clk),
        .reset        (reset),
        .consume_i    (fire && io.io_sigs_enq_cmdq),
        .return_i     (io.io_cmdq_credit_return),
        .count_o      (cmdq_cnt),
        .has_credit_o (cmdq_has),
        .at_max_o     (cmdq_full),
        .overflow_o   (cmdq_ovf)
    );

    credit_counter #(.CREDITS(XIMM1Q_CREDITS)) u_ximm_cnt (
        .clk          (clk),
        .reset        (reset),
        .consume_i    (fire && io.io_sigs_enq_ximm1q),
        .return_i     (io.io_ximm1q_credit_return),
        .count_o      (ximm_cnt),
        .has_credit_o (ximm_has),
        .at_max_o     (ximm_full),
        .overflow_o   (ximm_ovf)
    );

    // Exit from DRAIN looks at the registered counts, so a drain with all
    // credits already home lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (io.io_flush)            state_d = DRAIN;
            DRAIN:   if (cmdq_full && ximm_full) state_d = RUN;
            default:                             state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            cmdq_valid_q <= 1'b0;
            ximm_valid_q <= 1'b0;
            cmdq_bits_q  <= '0;
            ximm_bits_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmdq_valid_q <= fire && io.io_sigs_enq_cmdq;
            ximm_valid_q <= fire && io.io_sigs_enq_ximm1q;
            if (fire && io.io_sigs_enq_cmdq)   cmdq_bits_q <= io.io_cmd_bits;
            if (fire && io.io_sigs_enq_ximm1q) ximm_bits_q <= io.io_imm_bits;
            if (cmdq_ovf || ximm_ovf)          err_q       <= 1'b1;
        end
    end

    assign io.io_fire         = fire;
    assign io.io_replay       = io.io_valid && !fire;
    assign io.io_cmdq_valid   = cmdq_valid_q;
    assign io.io_ximm1q_valid = ximm_valid_q;
    assign io.io_cmdq_bits    = cmdq_bits_q;
    assign io.io_ximm1q_bits  = ximm_bits_q;
    assign io.io_busy         = (state_q == DRAIN);
    assign io.io_credit_err   = err_q;

    // Counts are observed through the counter instances; keep the local
    // copies referenced so the wiring stays explicit.
    logic unused_cnt;
    assign unused_cnt = ^{cmdq_cnt, ximm_cnt};
endmodule
